// File: rtl/lab7soc_led_fader_if.sv
`default_nettype none
// ============================================================================
// Module      : lab7soc_led_fader_if
// Description : Pattern/enable inputs and LED/busy outputs of the LED fader.
//               The master side is the PIO/SoC; the slave side is the fader.
// Revision    : 1.0 - initial release
// ============================================================================
interface lab7soc_led_fader_if #(
    parameter int WIDTH = 14
);
    logic [WIDTH-1:0] pattern_in;
    logic             enable;
    logic [WIDTH-1:0] led_out;
    logic             busy;

    modport master (
        output pattern_in,
        output enable,
        input  led_out,
        input  busy
    );

    modport slave (
        input  pattern_in,
        input  enable,
        output led_out,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/lab7soc_led_fader.sv
`default_nettype none
// ============================================================================
// Module      : lab7soc_led_fader
// Description : Per-LED PWM fader. Each LED brightness ramps linearly toward
//               the PIO pattern bit (one step per STEP_DIV clocks); bypass
//               mode passes the registered pattern straight to the pins.
// Revision    : 1.0 - initial release
// ============================================================================
module lab7soc_led_fader #(
    parameter int WIDTH    = 14,
    parameter int PWM_BITS = 4,
    parameter int STEP_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    lab7soc_led_fader_if.slave   bus
);

    // Prescaler needs at least one bit even when STEP_DIV = 1.
    localparam int                    c_PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PWM_BITS-1:0]   c_MAX      = {PWM_BITS{1'b1}};
    localparam logic [c_PRE_W-1:0]    c_PRE_LAST = c_PRE_W'(STEP_DIV - 1);

    logic [WIDTH-1:0]    r_pattern_q;
    logic [c_PRE_W-1:0]  r_prescaler;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                w_tick;
    logic [WIDTH-1:0]    w_led;
    logic [WIDTH-1:0]    w_level_ne;

    // With STEP_DIV = 1 the prescaler sits at 0 and this is true every cycle.
    assign w_tick = (r_prescaler == c_PRE_LAST);

    // Shared state: pattern capture, step prescaler and common PWM phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pattern_q <= '0;
            r_prescaler <= '0;
            r_pwm_cnt   <= '0;
        end else begin
            r_pattern_q <= bus.pattern_in;
            r_pwm_cnt   <= r_pwm_cnt + PWM_BITS'(1);
            r_prescaler <= w_tick ? '0 : r_prescaler + c_PRE_W'(1);
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_led
            logic [PWM_BITS-1:0] r_level;
            logic                r_led;
            logic [PWM_BITS-1:0] w_target;

            assign w_target = r_pattern_q[i] ? c_MAX : '0;

            // Level ramp and output drive; bypass forces the level onto its
            // target so switching back to fade mode causes no visible step.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_level <= '0;
                    r_led   <= 1'b0;
                end else if (!bus.enable) begin
                    r_level <= w_target;
                    r_led   <= r_pattern_q[i];
                end else begin
                    if (w_tick) begin
                        if (r_pattern_q[i] && (r_level != c_MAX)) begin
                            r_level <= r_level + PWM_BITS'(1);
                        end else if (!r_pattern_q[i] && (r_level != '0)) begin
                            r_level <= r_level - PWM_BITS'(1);
                        end
                    end
                    // Full scale is forced on so MAX gives a steady 1.
                    r_led <= (r_level == c_MAX) || (r_level > r_pwm_cnt);
                end
            end

            assign w_led[i]      = r_led;
            assign w_level_ne[i] = (r_level != w_target);
        end
    endgenerate

    assign bus.led_out = w_led;
    assign bus.busy    = |w_level_ne;

endmodule
`default_nettype wire

// File: tb/tb_lab7soc_led_fader.sv
`default_nettype none
// ============================================================================
// Module      : tb_lab7soc_led_fader
// Description : Self-checking bench for lab7soc_led_fader (STEP_DIV = 4,
//               PWM_BITS = 4, WIDTH = 14).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lab7soc_led_fader;

    localparam int c_WIDTH = 14;

    typedef struct {
        logic               rst;
        logic               en;
        logic [c_WIDTH-1:0] pat;
        logic [c_WIDTH-1:0] led;
        logic               busy;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    lab7soc_led_fader_if #(.WIDTH(c_WIDTH)) bus ();

    lab7soc_led_fader #(
        .WIDTH    (c_WIDTH),
        .PWM_BITS (4),
        .STEP_DIV (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs, take one clock edge, land 1 time unit after it.
    task automatic step(input logic e, input logic [c_WIDTH-1:0] p);
        bus.enable     = e;
        bus.pattern_in = p;
        @(posedge clk);
        #1;
    endtask

    // Level after edge n since reset release: one step per 4 edges, with an
    // optional reversal whose cleared pattern is presented before edge rev+1.
    function automatic int lvl(input int n, input int rev);
        int up;
        int dn;
        if (rev == 0 || n <= rev) return (n / 4 > 15) ? 15 : n / 4;
        up = (rev / 4 > 15) ? 15 : rev / 4;
        dn = up - (n - rev) / 4;
        return (dn < 0) ? 0 : dn;
    endfunction

    function automatic int tgt(input int n, input int rev);
        return (rev == 0 || n <= rev) ? 15 : 0;
    endfunction

    task automatic do_reset();
        reset          = 1'b1;
        bus.enable     = 1'b1;
        bus.pattern_in = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Fade-mode run from reset release, checked cycle by cycle.
    task automatic ramp_check(input logic [c_WIDTH-1:0] mask, input int rev, input int ncyc);
        int lp;
        logic [c_WIDTH-1:0] exp_led;
        for (int n = 1; n <= ncyc; n++) begin
            step(1'b1, (rev != 0 && n > rev) ? '0 : mask);
            lp      = lvl(n - 1, rev);
            exp_led = (lp == 15 || lp > (n - 1) % 16) ? mask : '0;
            chk("ramp_led", bus.led_out, exp_led);
            chk("ramp_busy", bus.busy, (lvl(n, rev) != tgt(n, rev)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vec_t tbl[14];
        checks         = 0;
        errors         = 0;
        reset          = 1'b1;
        bus.enable     = 1'b0;
        bus.pattern_in = '0;

        // Bypass / enable toggling; entry k >= 1 is edge k after release.
        tbl[0]  = '{1'b1, 1'b0, 14'h0000, 14'h0000, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 14'h2AAA, 14'h0000, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 14'h2AAA, 14'h2AAA, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 14'h2AAA, 14'h2AAA, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 14'h2AAA, 14'h2AAA, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 14'h2AAA, 14'h2AAA, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 14'h2AAA, 14'h2AAA, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 14'h0000, 14'h2AAA, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 14'h0000, 14'h0000, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 14'h0155, 14'h0000, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 14'h0155, 14'h0000, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 14'h0155, 14'h0000, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 14'h0155, 14'h0000, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 14'h0155, 14'h0000, 1'b1};

        for (int i = 0; i < 14; i++) begin
            reset = tbl[i].rst;
            step(tbl[i].en, tbl[i].pat);
            chk($sformatf("vec%0d_led", i), bus.led_out, tbl[i].led);
            chk($sformatf("vec%0d_busy", i), bus.busy, tbl[i].busy);
        end

        // All LEDs ramping, then an asynchronous reset in the middle of a cycle.
        do_reset();
        ramp_check(14'h3FFF, 0, 34);
        chk("pre_reset_led", bus.led_out, 14'h3FFF);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset_led", bus.led_out, 14'h0000);
        chk("async_reset_busy", bus.busy, 1'b0);
        @(posedge clk);
        #1;
        chk("held_reset_led", bus.led_out, 14'h0000);
        chk("held_reset_busy", bus.busy, 1'b0);
        reset = 1'b0;
        ramp_check(14'h3FFF, 0, 70);

        // Single LED fade-up.
        do_reset();
        ramp_check(14'h0001, 0, 70);

        // LED 5 ramps to 7, then its bit is cleared and it fades back to 0.
        do_reset();
        ramp_check(14'h0020, 28, 80);

        // Enable drops on the tick edge (edge 12) while mid-ramp.
        do_reset();
        ramp_check(14'h3FFF, 0, 11);
        step(1'b0, 14'h3FFF);
        chk("tick_bypass_led", bus.led_out, 14'h3FFF);
        chk("tick_bypass_busy", bus.busy, 1'b0);
        step(1'b0, 14'h3FFF);
        chk("bypass_hold_led", bus.led_out, 14'h3FFF);
        chk("bypass_hold_busy", bus.busy, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 14'h3FFF);
            chk("reenable_led", bus.led_out, 14'h3FFF);
            chk("reenable_busy", bus.busy, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lab7soc_led_fader.md
# lab7soc_led_fader

Downstream of the LED PIO: takes the 14-bit pattern the PIO drives on its output port and drives the board LEDs with per-LED PWM brightness. Each LED ramps linearly toward its target instead of switching hard on or off. A bypass mode passes the pattern straight through. Sits between the PIO output and the top-level LED pins, in the same clock domain as the SoC.

## Interface
- WIDTH, 14, number of LEDs; must equal the PIO output width.
- PWM_BITS, 4, brightness resolution; MAX = 2^PWM_BITS − 1.
- STEP_DIV, 50000, clk cycles per brightness step; must be ≥ 1.

- clk  in  1  system clock, same as the PIO.
- reset  in  1  asynchronous, active-high reset; one clock domain only.
- pattern_in  in  WIDTH  target pattern from the PIO output port; 1 = on, 0 = off.
- enable  in  1  1 = fade mode, 0 = bypass.
- led_out  out  WIDTH  registered LED drive; 1 = lit.
- busy  out  1  1 while any LED level differs from its target.

## Operation
- pattern_q: registers pattern_in every cycle.
- Target per LED i = MAX if pattern_q[i], else 0.
- Prescaler: counts 0..STEP_DIV−1 and wraps to 0.
  - tick = (prescaler == STEP_DIV−1).
  - With STEP_DIV = 1, tick is asserted every cycle.
- PWM counter: PWM_BITS wide, increments every cycle, wraps MAX→0. Free-running in both modes.
- level[i]: PWM_BITS wide, updated only on a tick while enable = 1.
  - If pattern_q[i] = 1 and level < MAX: level + 1.
  - If pattern_q[i] = 0 and level > 0: level − 1.
  - Otherwise unchanged; never overflows or underflows.
- Target reversal mid-ramp: the ramp reverses from the current level on the next tick. No jump.
- Fade mode output: led_out[i] <= (level[i] == MAX) | (level[i] > pwm_cnt).
  - level 0 gives constant 0.
  - level MAX gives constant 1.
  - level k (0 < k < MAX) gives k cycles high per 2^PWM_BITS-cycle PWM period.
- Bypass mode (enable = 0):
  - led_out[i] <= pattern_q[i].
  - Every level[i] <= target[i] each cycle, so re-enabling produces no visible transition.
  - The prescaler keeps running.
- busy = OR over i of (level[i] != target[i]). Combinational from registers only.
- Reset values:
  - pattern_q = 0, all levels = 0, prescaler = 0, pwm_cnt = 0.
  - led_out = 0, busy = 0.
- Reset mid-ramp: all state returns to the reset values immediately. After release, ramps restart from level 0.

## Timing
- pattern_in → pattern_q: 1 cycle.
- busy rises 1 cycle after a pattern_in change that makes some target differ from its level.
- A level changes at the clock edge where tick = 1. led_out reflects the new level 1 cycle later.
- Full ramp 0→MAX or MAX→0: MAX ticks = MAX·STEP_DIV cycles, ±1 tick of phase depending on prescaler position.
- Bypass latency: pattern_in → led_out = 2 cycles.
- Simultaneous events:
  - enable falling on a tick cycle: bypass wins and levels snap to target.
  - A pattern change on a tick cycle: that tick uses the old pattern_q.
- PWM period: 2^PWM_BITS cycles. PWM phase is common to all LEDs.

## Test plan
Use STEP_DIV = 4, PWM_BITS = 4, WIDTH = 14 for all scenarios.

1. Reset behaviour: assert reset asynchronously mid-cycle with pattern_in = 14'h3FFF and enable = 1 → led_out = 0 and busy = 0 immediately. After release, busy = 1 after 1 cycle.
2. Fade-up: pattern_in 0 → 14'h0001 with enable = 1 →
   - level[0] steps 1, 2, … 15, one step every 4 cycles.
   - Each PWM period at level k shows exactly k high cycles on led_out[0].
   - busy falls the cycle after level[0] reaches 15 (about 60 cycles).
   - led_out[13:1] stays 0 throughout.
3. Reversal: ramp LED 5 up to level 7, then clear bit 5 → next tick level = 6, then counts down to 0. No step above 7 is observed, and led_out[5] settles to constant 0.
4. Bypass: enable = 0, pattern_in = 14'h2AAA → led_out = 14'h2AAA 2 cycles later and busy = 0. Set enable = 1 → led_out unchanged (levels already at MAX/0) and busy stays 0.
5. Bypass on a tick: drop enable on the same cycle tick = 1 while mid-ramp → level snaps to target with no partial step. Output equals pattern_q from the next cycle.
6. Mid-ramp reset: assert reset during a ramp with all 14 bits set → all levels return to 0. After release, the full ramp takes 60 ± 4 cycles and led_out reaches 14'h3FFF constant.
